apb_rr_arbiter: RTL and testbench
=================================

// Module: apb_rr_arbiter
// PURPOSE
//  Shares one APB master port among NREQ requesters (AHB-APB bridge, DMA, debug).
//  Uses round-robin arbitration and drives full SETUP/ACCESS APB phases.
//  Honours Pready wait states and Pslverr, with an optional watchdog on stalled slaves.
//  Sits between the requesters and the APB slave-select decode; Psel is one bit, decoded downstream.
// PARAMETERS
//  NREQ     3   number of requesters (2..8)
//  AW       32  address width
//  DW       32  data width
//  TIMEOUT  16  max ACCESS cycles with Pready=0 before forced error; 0 = watchdog disabled
// PORTS
//  Hclk       in   1        system clock, all logic on posedge
//  Hreset     in   1        synchronous, active-high reset
//  req        in   NREQ     per-requester transfer request, held until done
//  req_write  in   NREQ     1 = write, 0 = read
//  req_addr   in   NREQ*AW  requester i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW  requester i at [i*DW +: DW]
//  done       out  NREQ     one-hot, 1-cycle completion pulse
//  rdata      out  DW       read data, valid while done != 0
//  err        out  1        Pslverr or timeout, valid while done != 0
//  Psel       out  1        APB select
//  Penable    out  1        APB enable
//  Pwrite     out  1        APB direction
//  Paddr      out  AW       APB address
//  Pwdata     out  DW       APB write data
//  Prdata     in   DW       APB read data
//  Pready     in   1        APB ready
//  Pslverr    in   1        APB slave error
// BEHAVIOUR
//  Reset: Hreset=1 at posedge drives state to IDLE and rr_ptr to 0. It also zeroes done, rdata, err,
//   Psel, Penable, Pwrite, Paddr, Pwdata and the timeout counter. Any in-flight transfer is
//   abandoned with no done pulse.
//  All outputs are registered.
//  FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//  IDLE:
//   - If req != 0, grant the first requester with req=1, searching upward from rr_ptr and wrapping
//     modulo NREQ.
//   - Latch gnt_idx; latch Paddr, Pwdata and Pwrite from that requester's slices; go to SETUP.
//   - If req == 0, stay in IDLE.
//  SETUP: Psel=1, Penable=0. Unconditionally go to ACCESS.
//  ACCESS:
//   - Psel=1, Penable=1.
//   - If Pready=1: capture Prdata into rdata and Pslverr into err; go to DONE.
//   - If Pready=0 and TIMEOUT!=0 and tcnt==TIMEOUT-1: set err=1, rdata=0; go to DONE.
//   - Otherwise increment tcnt (width clog2(TIMEOUT+1)) and stay in ACCESS.
//   - tcnt clears on entry to SETUP.
//  DONE:
//   - Psel=0, Penable=0; done[gnt_idx]=1 for this one cycle.
//   - rr_ptr <= (gnt_idx+1) mod NREQ; go to IDLE.
//  rdata and err hold their value outside DONE; consumers sample them only with done.
//  Paddr, Pwdata and Pwrite hold their last granted values until the next grant.
//  Psel=Penable=0 in IDLE and DONE.
//  Requester rules:
//   - req and its addr/wdata/write stay stable from assertion until done.
//   - In the cycle after done, the requester may drop req or present a new transfer.
//   - A request arriving during a transfer waits; it is not lost.
//  Latency: Pready high on first ACCESS gives 4 cycles grant-to-grant.
//   Timing: IDLE grant at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, done at cycle 3.
//   Each Pready=0 cycle adds one.
//  Fairness: with all requesters asserting continuously, each is granted once per NREQ transfers.
//  Simultaneous events:
//   - Pready=1 on the timeout cycle counts as a normal completion, with err=Pslverr.
//   - Pslverr is ignored when Pready=0.
//  req dropped mid-transfer (protocol violation): the APB transfer still completes and done
//   still pulses.
// TESTING
//  T1: reset, req=3'b010 write addr=0x40 data=0xA5A5_0001, Pready=1
//      -> Psel at cyc1, Penable at cyc2, done=3'b010 at cyc3, err=0.
//  T2: read from req0, Pready low 3 cycles, Prdata=0x1234_5678
//      -> done at cyc6, rdata=0x1234_5678, Penable high cycles 2-5.
//  T3: req=3'b111 held, Pready=1
//      -> grant order 0,1,2,0,1,2; done every 4 cycles.
//  T4: TIMEOUT=16, Pready stuck 0
//      -> after 16 ACCESS cycles done pulses with err=1, rdata=0; next request then served.
//  T5: Pslverr=1 with Pready=1 on a write
//      -> done with err=1; Pslverr=1 with Pready=0 ignored.
//  T6: Hreset pulsed during ACCESS
//      -> next cycle all outputs 0, no done; rr_ptr=0, so req0 wins over req2.

Source files
------------

// File: rtl/apb_rr_arbiter_if.sv
// Requester and APB-side signals of the round-robin APB arbiter.
// master: the arbiter's view (drives APB, answers requesters).
// slave : the environment's view (requesters plus APB slave).
interface apb_rr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic               err;

    logic               Psel;
    logic               Penable;
    logic               Pwrite;
    logic [AW-1:0]      Paddr;
    logic [DW-1:0]      Pwdata;
    logic [DW-1:0]      Prdata;
    logic               Pready;
    logic               Pslverr;

    modport master (
        input  req, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
        output done, rdata, err, Psel, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
        input  done, rdata, err, Psel, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Runs full SETUP/ACCESS phases, honours Pready/Pslverr and optionally
// forces an error completion when a slave stalls for TIMEOUT ACCESS cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; pick next requester from rr_ptr upward
// SETUP  | APB setup phase, Psel=1 Penable=0
// ACCESS | APB access phase, waiting for Pready or watchdog expiry
// DONE   | one-cycle done pulse to the granted requester
module apb_rr_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input logic               Hclk,
    input logic               Hreset,
    apb_rr_arbiter_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TC_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [TW-1:0] tcnt;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          tc_hit;

    // Round-robin pick: scan downward so the candidate closest to rr_ptr is assigned last and wins.
    always_comb begin
        int c;
        c        = 0;
        pick_idx = rr_ptr;
        pick_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(rr_ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (bus.req[IW'(c)]) begin
                pick_idx = IW'(c);
                pick_vld = 1'b1;
            end
        end
    end

    // Watchdog expiry: last permitted stalled ACCESS cycle, only when the watchdog is enabled.
    always_comb begin
        tc_hit = (TIMEOUT != 0) && (tcnt == TC_LAST);
    end

    // Transfer sequencer with all bus and requester-facing outputs registered.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            tcnt        <= '0;
            bus.done    <= '0;
            bus.rdata   <= '0;
            bus.err     <= 1'b0;
            bus.Psel    <= 1'b0;
            bus.Penable <= 1'b0;
            bus.Pwrite  <= 1'b0;
            bus.Paddr   <= '0;
            bus.Pwdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_idx    <= pick_idx;
                        bus.Paddr  <= bus.req_addr[int'(pick_idx)*AW +: AW];
                        bus.Pwdata <= bus.req_wdata[int'(pick_idx)*DW +: DW];
                        bus.Pwrite <= bus.req_write[pick_idx];
                        bus.Psel   <= 1'b1;
                        tcnt       <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    bus.Penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave always wins over the watchdog in the same cycle.
                    if (bus.Pready) begin
                        bus.rdata   <= bus.Prdata;
                        bus.err     <= bus.Pslverr;
                        bus.Psel    <= 1'b0;
                        bus.Penable <= 1'b0;
                        bus.done    <= NREQ'(1) << gnt_idx;
                        state       <= DONE;
                    end else if (tc_hit) begin
                        bus.rdata   <= '0;
                        bus.err     <= 1'b1;
                        bus.Psel    <= 1'b0;
                        bus.Penable <= 1'b0;
                        bus.done    <= NREQ'(1) << gnt_idx;
                        state       <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE: begin
                    bus.done <= '0;
                    rr_ptr   <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed requester stimulus,
// a behavioural APB slave with programmable wait states and errors, and a
// scoreboard of expected completions checked on every done pulse.
module tb_apb_rr_arbiter;
    localparam int NREQ    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          acc;
    } exp_t;

    logic Hclk;
    logic Hreset;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    int          wait_cfg;
    bit          slv_err;
    bit          slv_err_wait;
    logic [31:0] slv_rdata;

    apb_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus.master)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Hclk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // APB slave model: Pready after wait_cfg stalled ACCESS cycles.
    initial begin
        int acc_cnt;
        acc_cnt     = 0;
        bus.Pready  = 1'b0;
        bus.Pslverr = 1'b0;
        bus.Prdata  = '0;
        forever begin
            @(negedge Hclk);
            if (bus.Psel === 1'b1 && bus.Penable === 1'b1) begin
                bus.Pready  = (acc_cnt >= wait_cfg);
                bus.Pslverr = bus.Pready ? slv_err : slv_err_wait;
                bus.Prdata  = slv_rdata;
                acc_cnt++;
            end else begin
                bus.Pready  = 1'b0;
                bus.Pslverr = 1'b0;
                bus.Prdata  = ~slv_rdata;
                acc_cnt     = 0;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    initial begin
        int   setup_cyc;
        int   pen_cnt;
        exp_t e;
        setup_cyc = 0;
        pen_cnt   = 0;
        forever begin
            @(negedge Hclk);
            if (bus.Psel === 1'b1 && bus.Penable === 1'b0) begin
                setup_cyc = cyc;
                pen_cnt   = 0;
            end
            if (bus.Penable === 1'b1) begin
                pen_cnt++;
            end
            if (bus.done !== '0 && Hreset !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_vec", bus.done, 64'(NREQ'(1) << e.idx));
                    check("err", bus.err, e.err);
                    check("rdata", bus.rdata, e.rdata);
                    check("Paddr", bus.Paddr, e.addr);
                    check("Pwrite", bus.Pwrite, e.wr);
                    if (e.wr) begin
                        check("Pwdata", bus.Pwdata, e.wdata);
                    end
                    check("access_cycles", pen_cnt, e.acc);
                    check("setup_to_done", cyc - setup_cyc, e.acc + 1);
                end
            end
        end
    end

    task automatic drive_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_write[i]         = wr;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req[i]               = 1'b1;
    endtask

    task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input bit e, input int acc);
        exp_t x;
        drive_req(i, wr, a, d);
        x.idx = i; x.wr = wr; x.addr = a; x.wdata = d; x.rdata = rd; x.err = e; x.acc = acc;
        sb.push_back(x);
    endtask

    task automatic wait_done(output int idx);
        bit seen;
        seen = 1'b0;
        idx  = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge Hclk);
            if (bus.done !== '0) begin
                seen = 1'b1;
                for (int j = 0; j < NREQ; j++) begin
                    if (bus.done[j] === 1'b1) idx = j;
                end
            end
        end
        check("done_seen", seen, 1);
    endtask

    task automatic do_reset();
        @(negedge Hclk);
        Hreset  = 1'b1;
        bus.req = '0;
        @(negedge Hclk);
        Hreset  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_done"},    bus.done, 0);
        check({pfx, "_Psel"},    bus.Psel, 0);
        check({pfx, "_Penable"}, bus.Penable, 0);
        check({pfx, "_err"},     bus.err, 0);
        check({pfx, "_rdata"},   bus.rdata, 0);
        check({pfx, "_Paddr"},   bus.Paddr, 0);
        check({pfx, "_Pwdata"},  bus.Pwdata, 0);
        check({pfx, "_Pwrite"},  bus.Pwrite, 0);
    endtask

    initial begin
        int idx;
        int last_cyc;
        n_checks      = 0;
        n_errors      = 0;
        Hreset        = 1'b1;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        wait_cfg      = 0;
        slv_err       = 1'b0;
        slv_err_wait  = 1'b0;
        slv_rdata     = 32'h0BAD_F00D;
        repeat (3) @(negedge Hclk);
        Hreset = 1'b0;
        check_idle_outputs("reset");

        // T1: single write from requester 1, phase-by-phase timing.
        issue(1, 1'b1, 32'h40, 32'hA5A5_0001, 32'h0BAD_F00D, 1'b0, 1);
        @(negedge Hclk);
        check("t1_c1_Psel", bus.Psel, 1);
        check("t1_c1_Penable", bus.Penable, 0);
        @(negedge Hclk);
        check("t1_c2_Psel", bus.Psel, 1);
        check("t1_c2_Penable", bus.Penable, 1);
        @(negedge Hclk);
        check("t1_c3_done", bus.done, 3'b010);
        check("t1_c3_Psel", bus.Psel, 0);
        bus.req[1] = 1'b0;

        // T2: read with three wait states.
        do_reset();
        wait_cfg  = 3;
        slv_rdata = 32'h1234_5678;
        issue(0, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 4);
        wait_done(idx);
        check("t2_idx", idx, 0);
        bus.req[0] = 1'b0;

        // T3: all requesters held, round-robin order and 4-cycle spacing.
        do_reset();
        wait_cfg  = 0;
        slv_rdata = 32'hCAFE_0003;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                issue(i, i[0], 32'h100 + 32'(i * 4), 32'h5000 + 32'(i), 32'hCAFE_0003, 1'b0, 1);
            end
        end
        last_cyc = 0;
        for (int n = 0; n < 6; n++) begin
            wait_done(idx);
            check("t3_order", idx, n % NREQ);
            if (n > 0) check("t3_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
        end
        bus.req = '0;

        // T4: stuck slave hits the watchdog; a request arriving meanwhile is served next.
        do_reset();
        wait_cfg  = 1000;
        slv_rdata = 32'h7777_0004;
        issue(2, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, TIMEOUT);
        repeat (3) @(negedge Hclk);
        issue(0, 1'b1, 32'h84, 32'hBEEF_0004, 32'h7777_0004, 1'b0, 1);
        wait_done(idx);
        check("t4_timeout_idx", idx, 2);
        bus.req[2] = 1'b0;
        wait_cfg   = 0;
        wait_done(idx);
        check("t4_next_idx", idx, 0);
        bus.req[0] = 1'b0;

        // Pready arriving on the last watchdog cycle is a normal completion.
        wait_cfg  = TIMEOUT - 1;
        slv_rdata = 32'h4444_0015;
        issue(1, 1'b0, 32'h90, 32'h0, 32'h4444_0015, 1'b0, TIMEOUT);
        wait_done(idx);
        check("t4b_idx", idx, 1);
        bus.req[1] = 1'b0;

        // T5: slave error with Pready, then error asserted only during wait states.
        wait_cfg  = 0;
        slv_err   = 1'b1;
        slv_rdata = 32'h5555_0005;
        issue(1, 1'b1, 32'hA0, 32'h1111_0005, 32'h5555_0005, 1'b1, 1);
        wait_done(idx);
        check("t5_err_idx", idx, 1);
        bus.req[1]   = 1'b0;
        slv_err      = 1'b0;
        slv_err_wait = 1'b1;
        wait_cfg     = 2;
        issue(0, 1'b1, 32'hA4, 32'h2222_0005, 32'h5555_0005, 1'b0, 3);
        wait_done(idx);
        check("t5_ign_idx", idx, 0);
        bus.req[0]   = 1'b0;
        slv_err_wait = 1'b0;

        // T6: reset during ACCESS abandons the transfer; req0 then beats req2.
        wait_cfg  = 5;
        slv_rdata = 32'h6666_0006;
        drive_req(2, 1'b0, 32'hC0, 32'h0);
        for (int k = 0; k < 20 && bus.Penable !== 1'b1; k++) @(negedge Hclk);
        check("t6_in_access", bus.Penable, 1);
        Hreset   = 1'b1;
        wait_cfg = 0;
        issue(0, 1'b1, 32'hC4, 32'h3333_0006, 32'h6666_0006, 1'b0, 1);
        begin
            exp_t x;
            x.idx = 2; x.wr = 1'b0; x.addr = 32'hC0; x.wdata = 32'h0;
            x.rdata = 32'h6666_0006; x.err = 1'b0; x.acc = 1;
            sb.push_back(x);
        end
        @(negedge Hclk);
        Hreset = 1'b0;
        check_idle_outputs("t6_post_reset");
        wait_done(idx);
        check("t6_first_idx", idx, 0);
        bus.req[0] = 1'b0;
        wait_done(idx);
        check("t6_second_idx", idx, 2);
        bus.req[2] = 1'b0;

        repeat (6) @(negedge Hclk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
